// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-sequence detector (KMP automaton, overlap selectable).
// Define SEQ_DET_COUNT_EN to add the saturating hit counter (CNT_W parameter and CNT port).
module seq_detector_param #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1
`ifdef SEQ_DET_COUNT_EN
  , parameter int unsigned  CNT_W   = 8
`endif
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       x,
  output logic                       F,
  output logic [$clog2(LEN+1)-1:0]   S
`ifdef SEQ_DET_COUNT_EN
  , output logic [CNT_W-1:0]         CNT
`endif
);

  localparam int unsigned SW = $clog2(LEN + 1);

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(int i);
    logic [LEN-1:0] t;
    t = PATTERN >> (LEN - 1 - i);
    return t[0];
  endfunction

  // Longest proper pattern prefix that is also a suffix of the whole pattern.
  function automatic int fail_len();
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < int'(LEN); k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pat_bit(i) != pat_bit(int'(LEN) - k + i)) ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

  // Successor of state s on bit b: longest prefix that is a suffix of (prefix(base), b).
  function automatic int next_state(int s, logic b);
    int   base;
    int   res;
    int   j;
    logic ok;
    logic sb;
    if (s >= int'(LEN)) base = OVERLAP ? fail_len() : 0;
    else                base = s;
    res = 0;
    for (int k = 1; k <= base + 1; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j  = base + 1 - k + i;
        sb = (j == base) ? b : pat_bit(j);
        if (sb != pat_bit(i)) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  // Transition table, constant after elaboration.
  logic [SW-1:0] nxt_tab [LEN+1][2];

  for (genvar g = 0; g <= LEN; g++) begin : g_tab
    assign nxt_tab[g][0] = SW'(next_state(g, 1'b0));
    assign nxt_tab[g][1] = SW'(next_state(g, 1'b1));
  end

  logic [SW-1:0] s_q, s_d;
  logic          f_q, f_d;

  // Next state; F is decoded from the next state so it lands in the same edge as S.
  always_comb begin
    s_d = s_q;
    if (EN) s_d = nxt_tab[s_q][x];
    f_d = (s_d == SW'(LEN));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_q <= '0;
      f_q <= 1'b0;
    end else begin
      s_q <= s_d;
      f_q <= f_d;
    end
  end

  assign S = s_q;
  assign F = f_q;

`ifdef SEQ_DET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of edges that land in the full-match state.
  always_comb begin
    cnt_d = cnt_q;
    if (EN && (s_d == SW'(LEN)) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: overlap and non-overlap instances against a history-based model.
module tb_seq_detector_param;

  localparam int unsigned    LEN = 4;
  localparam logic [LEN-1:0] PAT = 4'b1011;
  localparam int unsigned    CW  = 2;
  localparam int             CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       x   = 1'b0;
  logic       f_ov, f_no;
  logic [2:0] s_ov, s_no;
`ifdef SEQ_DET_COUNT_EN
  logic [CW-1:0] cnt_ov, cnt_no;
`endif

  int checks = 0;
  int errors = 0;

  bit hist_ov[$];
  bit hist_no[$];
  int m_s_ov = 0, m_s_no = 0, m_cnt_ov = 0, m_cnt_no = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b1)
`ifdef SEQ_DET_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut_ov (
    .CLK(clk), .RESET(rst), .EN(en), .x(x), .F(f_ov), .S(s_ov)
`ifdef SEQ_DET_COUNT_EN
    , .CNT(cnt_ov)
`endif
  );

  seq_detector_param #(
    .LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b0)
`ifdef SEQ_DET_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut_no (
    .CLK(clk), .RESET(rst), .EN(en), .x(x), .F(f_no), .S(s_no)
`ifdef SEQ_DET_COUNT_EN
    , .CNT(cnt_no)
`endif
  );

  // Longest pattern prefix that equals the tail of the consumed history.
  function automatic int prefix_match(bit h[$]);
    int n;
    int best;
    bit ok;
    n = h.size();
    best = 0;
    for (int k = 1; k <= int'(LEN); k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[n - k + i] != PAT[int'(LEN) - 1 - i]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic b);
    if (r) begin
      hist_ov.delete();
      hist_no.delete();
      m_s_ov = 0; m_s_no = 0; m_cnt_ov = 0; m_cnt_no = 0;
    end else if (e) begin
      if (m_s_no == int'(LEN)) hist_no.delete();
      hist_ov.push_back(b);
      hist_no.push_back(b);
      if (hist_ov.size() > LEN) void'(hist_ov.pop_front());
      if (hist_no.size() > LEN) void'(hist_no.pop_front());
      m_s_ov = prefix_match(hist_ov);
      m_s_no = prefix_match(hist_no);
      if (m_s_ov == int'(LEN) && m_cnt_ov < CMAX) m_cnt_ov++;
      if (m_s_no == int'(LEN) && m_cnt_no < CMAX) m_cnt_no++;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic b);
    @(negedge clk);
    rst = r; en = e; x = b;
    @(posedge clk);
    model_step(r, e, b);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (s_ov !== 3'd0 || f_ov !== 1'b0 || s_no !== 3'd0 || f_no !== 1'b0) begin
      errors++;
      $display("FAIL reset: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected all 0", s_ov, f_ov, s_no, f_no);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (s_ov !== 3'd0 || s_no !== 3'd0) begin
        errors++;
        $display("FAIL reset_zeros[%0d]: S_ov=%0d S_no=%0d expected 0", i, s_ov, s_no);
      end
    end
  endtask

  task automatic test_detect();
    int bits[4] = '{1, 0, 1, 1};
    int es[4]   = '{1, 2, 3, 4};
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'(bits[i]));
      checks++;
      if (s_ov !== 3'(es[i]) || f_ov !== (i == 3) || s_no !== 3'(m_s_no)) begin
        errors++;
        $display("FAIL detect[%0d]: S_ov=%0d F_ov=%0d S_no=%0d expected %0d %0d %0d",
                 i, s_ov, f_ov, s_no, es[i], (i == 3), m_s_no);
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_ov !== 3'd2 || f_ov !== 1'b0 || s_no !== 3'(m_s_no) || f_no !== 1'b0) begin
      errors++;
      $display("FAIL detect_after: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected 2 0 %0d 0",
               s_ov, f_ov, s_no, f_no, m_s_no);
    end
  endtask

  task automatic test_overlap();
    int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int fo[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int fn[7]   = '{0, 0, 0, 1, 0, 0, 0};
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'(bits[i]));
      checks++;
      if (f_ov !== 1'(fo[i]) || f_no !== 1'(fn[i])) begin
        errors++;
        $display("FAIL overlap_f[%0d]: F_ov=%0d F_no=%0d expected %0d %0d", i, f_ov, f_no, fo[i], fn[i]);
      end
    end
    checks++;
    if (s_no !== 3'd1 || s_ov !== 3'd4) begin
      errors++;
      $display("FAIL overlap_s: S_no=%0d S_ov=%0d expected 1 4", s_no, s_ov);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (s_ov !== 3'd3 || s_no !== 3'd3) begin
      errors++;
      $display("FAIL mid_reset_pre: S_ov=%0d S_no=%0d expected 3", s_ov, s_no);
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (s_ov !== 3'd0 || f_ov !== 1'b0 || s_no !== 3'd0 || f_no !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected 0", s_ov, f_ov, s_no, f_no);
    end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (s_ov !== 3'd1 || f_ov !== 1'b0 || s_no !== 3'd1 || f_no !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_post: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected 1 0 1 0",
               s_ov, f_ov, s_no, f_no);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'(i % 2));
      checks++;
      if (s_ov !== 3'd2 || s_no !== 3'd2) begin
        errors++;
        $display("FAIL hold[%0d]: S_ov=%0d S_no=%0d expected 2", i, s_ov, s_no);
      end
    end
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (s_ov !== 3'd4 || f_ov !== 1'b1 || s_no !== 3'd4 || f_no !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected 4 1 4 1",
               s_ov, f_ov, s_no, f_no);
    end
  endtask

`ifdef SEQ_DET_COUNT_EN
  task automatic test_count();
    int bits[4] = '{1, 0, 1, 1};
    int ec[5]   = '{1, 2, 3, 3, 3};
    drive(1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'(bits[i]));
      checks++;
      if (cnt_ov !== CW'(ec[p]) || cnt_no !== CW'(ec[p])) begin
        errors++;
        $display("FAIL count[%0d]: CNT_ov=%0d CNT_no=%0d expected %0d", p, cnt_ov, cnt_no, ec[p]);
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt_ov !== '0 || cnt_no !== '0) begin
      errors++;
      $display("FAIL count_reset: CNT_ov=%0d CNT_no=%0d expected 0", cnt_ov, cnt_no);
    end
  endtask
`endif

  task automatic test_random();
    logic r, e, b;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 80);
      b = 1'($urandom_range(0, 1));
      drive(r, e, b);
      checks++;
      if (s_ov !== 3'(m_s_ov) || f_ov !== (m_s_ov == int'(LEN)) ||
          s_no !== 3'(m_s_no) || f_no !== (m_s_no == int'(LEN))) begin
        errors++;
        $display("FAIL random[%0d]: S_ov=%0d F_ov=%0d S_no=%0d F_no=%0d expected %0d %0d %0d %0d",
                 i, s_ov, f_ov, s_no, f_no, m_s_ov, (m_s_ov == int'(LEN)), m_s_no, (m_s_no == int'(LEN)));
      end
`ifdef SEQ_DET_COUNT_EN
      checks++;
      if (cnt_ov !== CW'(m_cnt_ov) || cnt_no !== CW'(m_cnt_no)) begin
        errors++;
        $display("FAIL random_cnt[%0d]: CNT_ov=%0d CNT_no=%0d expected %0d %0d",
                 i, cnt_ov, cnt_no, m_cnt_ov, m_cnt_no);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_detect();
    test_overlap();
    test_mid_reset();
    test_hold();
`ifdef SEQ_DET_COUNT_EN
    test_count();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
